// File: rtl/macpu_pkg.sv
// Shared MACPU types and constants for the interrupt sequencer.
package macpu_pkg;

  localparam int unsigned VEC_W      = 16;
  localparam int unsigned SOFT_NUM_W = 5;
  localparam int unsigned PEND_W     = 3;

  localparam logic [VEC_W-1:0] DEF_INTA_VEC  = 16'hFDA9;
  localparam logic [VEC_W-1:0] DEF_INTB_VEC  = 16'hFB53;
  localparam logic [VEC_W-1:0] DEF_SOFT_BASE = 16'h0100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_SERVICE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_INTA = 2'b01,
    SRC_INTB = 2'b10,
    SRC_SOFT = 2'b11
  } src_e;

  typedef enum logic [1:0] {
    CFG_EN       = 2'b00,
    CFG_VEC_A    = 2'b01,
    CFG_VEC_B    = 2'b10,
    CFG_DEFAULTS = 2'b11
  } cfg_sel_e;

  // Software vector table entries are 16 bytes apart; the sum wraps in 16 bits.
  function automatic logic [VEC_W-1:0] soft_vector(input logic [VEC_W-1:0] base,
                                                   input logic [SOFT_NUM_W-1:0] num);
    return VEC_W'(base + {7'd0, num, 4'b0000});
  endfunction

endpackage

// File: rtl/int_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a rising-edge pulse.
module int_sync_edge (
  input  logic clk,
  input  logic n_rst,
  input  logic async_in,
  output logic rise_c
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  // Metastability filter plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= async_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign rise_c = sync2 & ~sync2_d;

endmodule

// File: rtl/int_sequencer.sv
// MACPU interrupt sequencer: pending latches, arbitration, req/ack/iret FSM, config regs.
module int_sequencer
  import macpu_pkg::*;
#(
  parameter logic [15:0] INTA_VEC_RST = DEF_INTA_VEC,
  parameter logic [15:0] INTB_VEC_RST = DEF_INTB_VEC,
  parameter logic [15:0] SOFT_BASE    = DEF_SOFT_BASE
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_inta,
  input  logic                  i_intb,
  input  logic                  i_soft_req,
  input  logic [SOFT_NUM_W-1:0] i_soft_num,
  input  logic                  i_cfg_we,
  input  logic [1:0]            i_cfg_sel,
  input  logic [VEC_W-1:0]      i_cfg_data,
  input  logic                  i_ack,
  input  logic                  i_iret,
  output logic                  o_int_req,
  output logic [VEC_W-1:0]      o_int_vector,
  output logic [1:0]            o_int_src,
  output logic                  o_in_service,
  output logic [PEND_W-1:0]     o_pending,
  output logic [2:0]            o_cfg
);

  logic rise_a_c;
  logic rise_b_c;

  state_e                state;
  src_e                  src_q;
  logic [VEC_W-1:0]      vec_q;
  logic                  req_q;
  logic                  svc_q;
  logic [PEND_W-1:0]     pend;
  logic [SOFT_NUM_W-1:0] soft_num_q;
  logic [VEC_W-1:0]      vec_a;
  logic [VEC_W-1:0]      vec_b;
  logic                  en_a;
  logic                  en_b;
  logic                  prio_b;

  logic [PEND_W-1:0] kill;
  logic [PEND_W-1:0] ack_clr;
  logic [PEND_W-1:0] set_bits;
  logic [PEND_W-1:0] avail;
  src_e              win_src;
  logic [VEC_W-1:0]  win_vec;
  logic              soft_cap;

  int_sync_edge u_sync_a (.clk(clk), .n_rst(n_rst), .async_in(i_inta), .rise_c(rise_a_c));
  int_sync_edge u_sync_b (.clk(clk), .n_rst(n_rst), .async_in(i_intb), .rise_c(rise_b_c));

  // Pending set/clear terms and arbitration of whatever survives this cycle's disables.
  always_comb begin
    kill     = '0;
    ack_clr  = '0;
    set_bits = {i_soft_req, rise_b_c & en_b, rise_a_c & en_a};
    win_src  = SRC_NONE;
    win_vec  = '0;
    if (i_cfg_we && (cfg_sel_e'(i_cfg_sel) == CFG_EN)) begin
      kill[0] = ~i_cfg_data[0] && !((state == ST_REQ) && (src_q == SRC_INTA));
      kill[1] = ~i_cfg_data[1] && !((state == ST_REQ) && (src_q == SRC_INTB));
    end
    if ((state == ST_REQ) && i_ack) begin
      ack_clr[0] = (src_q == SRC_INTA);
      ack_clr[1] = (src_q == SRC_INTB);
      ack_clr[2] = (src_q == SRC_SOFT);
    end
    soft_cap = i_soft_req && (!pend[2] || ack_clr[2]);
    avail    = pend & ~kill;
    if (avail[0] && avail[1]) begin
      win_src = prio_b ? SRC_INTB : SRC_INTA;
      win_vec = prio_b ? vec_b : vec_a;
    end else if (avail[0]) begin
      win_src = SRC_INTA;
      win_vec = vec_a;
    end else if (avail[1]) begin
      win_src = SRC_INTB;
      win_vec = vec_b;
    end else if (avail[2]) begin
      win_src = SRC_SOFT;
      win_vec = soft_vector(SOFT_BASE, soft_num_q);
    end
  end

  // Pending bits (set beats clear) and the captured software interrupt number.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend       <= '0;
      soft_num_q <= '0;
    end else begin
      pend <= (pend & ~(kill | ack_clr)) | set_bits;
      if (soft_cap) soft_num_q <= i_soft_num;
    end
  end

  // Configuration registers; writes land at the next edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vec_a  <= INTA_VEC_RST;
      vec_b  <= INTB_VEC_RST;
      en_a   <= 1'b1;
      en_b   <= 1'b1;
      prio_b <= 1'b0;
    end else if (i_cfg_we) begin
      case (cfg_sel_e'(i_cfg_sel))
        CFG_EN: begin
          en_a   <= i_cfg_data[0];
          en_b   <= i_cfg_data[1];
          prio_b <= i_cfg_data[2];
        end
        CFG_VEC_A: vec_a <= i_cfg_data;
        CFG_VEC_B: vec_b <= i_cfg_data;
        CFG_DEFAULTS: begin
          vec_a  <= INTA_VEC_RST;
          vec_b  <= INTB_VEC_RST;
          en_a   <= 1'b1;
          en_b   <= 1'b1;
          prio_b <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Entry handshake FSM with registered request/service/vector/source outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_IDLE;
      req_q <= 1'b0;
      svc_q <= 1'b0;
      src_q <= SRC_NONE;
      vec_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_src != SRC_NONE) begin
            state <= ST_REQ;
            req_q <= 1'b1;
            src_q <= win_src;
            vec_q <= win_vec;
          end
        end
        ST_REQ: begin
          if (i_ack) begin
            state <= ST_SERVICE;
            req_q <= 1'b0;
            svc_q <= 1'b1;
          end
        end
        ST_SERVICE: begin
          if (i_iret) begin
            state <= ST_IDLE;
            svc_q <= 1'b0;
            src_q <= SRC_NONE;
            vec_q <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          req_q <= 1'b0;
          svc_q <= 1'b0;
          src_q <= SRC_NONE;
          vec_q <= '0;
        end
      endcase
    end
  end

  assign o_int_req    = req_q;
  assign o_int_vector = vec_q;
  assign o_int_src    = src_q;
  assign o_in_service = svc_q;
  assign o_pending    = pend;
  assign o_cfg        = {prio_b, en_b, en_a};

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: directed table, corner sequences, random vs model.
module tb_int_sequencer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        i_inta, i_intb, i_soft_req, i_cfg_we, i_ack, i_iret;
  logic [4:0]  i_soft_num;
  logic [1:0]  i_cfg_sel;
  logic [15:0] i_cfg_data;
  logic        o_int_req, o_in_service;
  logic [15:0] o_int_vector;
  logic [1:0]  o_int_src;
  logic [2:0]  o_pending, o_cfg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  int_sequencer dut (
    .clk(clk), .n_rst(n_rst), .i_inta(i_inta), .i_intb(i_intb),
    .i_soft_req(i_soft_req), .i_soft_num(i_soft_num), .i_cfg_we(i_cfg_we),
    .i_cfg_sel(i_cfg_sel), .i_cfg_data(i_cfg_data), .i_ack(i_ack), .i_iret(i_iret),
    .o_int_req(o_int_req), .o_int_vector(o_int_vector), .o_int_src(o_int_src),
    .o_in_service(o_in_service), .o_pending(o_pending), .o_cfg(o_cfg)
  );

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_REQ = 1, M_SVC = 2;
  int          m_phase;
  bit          m_ah[$];
  bit          m_bh[$];
  bit          m_pa, m_pb, m_ps;
  int          m_num;
  int          m_va, m_vb, m_vec, m_src;
  bit          m_ea, m_eb, m_pr;

  task automatic model_reset();
    m_phase = M_IDLE;
    m_ah = '{0, 0, 0};
    m_bh = '{0, 0, 0};
    m_pa = 0; m_pb = 0; m_ps = 0; m_num = 0;
    m_va = 'hFDA9; m_vb = 'hFB53; m_vec = 0; m_src = 0;
    m_ea = 1; m_eb = 1; m_pr = 0;
  endtask

  task automatic model_step();
    bit edge_a, edge_b, kill_a, kill_b, done_a, done_b, done_s;
    bit new_a, new_b, new_s;
    int order[3];
    edge_a = m_ah[1] && !m_ah[2];
    edge_b = m_bh[1] && !m_bh[2];
    void'(m_ah.pop_back()); m_ah.push_front(i_inta);
    void'(m_bh.pop_back()); m_bh.push_front(i_intb);
    kill_a = i_cfg_we && i_cfg_sel == 0 && !i_cfg_data[0] && !(m_phase == M_REQ && m_src == 1);
    kill_b = i_cfg_we && i_cfg_sel == 0 && !i_cfg_data[1] && !(m_phase == M_REQ && m_src == 2);
    done_a = m_phase == M_REQ && i_ack && m_src == 1;
    done_b = m_phase == M_REQ && i_ack && m_src == 2;
    done_s = m_phase == M_REQ && i_ack && m_src == 3;
    if (i_soft_req && (!m_ps || done_s)) m_num = i_soft_num;
    new_a = (m_pa && !kill_a && !done_a) || (edge_a && m_ea);
    new_b = (m_pb && !kill_b && !done_b) || (edge_b && m_eb);
    new_s = (m_ps && !done_s) || i_soft_req;
    case (m_phase)
      M_IDLE: begin
        order = m_pr ? '{2, 1, 3} : '{1, 2, 3};
        foreach (order[k]) begin
          if (m_phase == M_IDLE) begin
            if (order[k] == 1 && m_pa && !kill_a) begin m_phase = M_REQ; m_src = 1; m_vec = m_va; end
            if (order[k] == 2 && m_pb && !kill_b) begin m_phase = M_REQ; m_src = 2; m_vec = m_vb; end
            if (order[k] == 3 && m_ps) begin
              m_phase = M_REQ; m_src = 3; m_vec = ('h100 + m_num * 16) % 65536;
            end
          end
        end
      end
      M_REQ: if (i_ack) m_phase = M_SVC;
      default: if (i_iret) begin m_phase = M_IDLE; m_src = 0; m_vec = 0; end
    endcase
    m_pa = new_a; m_pb = new_b; m_ps = new_s;
    if (i_cfg_we) begin
      case (i_cfg_sel)
        2'd0: begin m_ea = i_cfg_data[0]; m_eb = i_cfg_data[1]; m_pr = i_cfg_data[2]; end
        2'd1: m_va = i_cfg_data;
        2'd2: m_vb = i_cfg_data;
        default: begin m_va = 'hFDA9; m_vb = 'hFB53; m_ea = 1; m_eb = 1; m_pr = 0; end
      endcase
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("int_req",    32'(o_int_req),    32'(m_phase == M_REQ));
    check("in_service", 32'(o_in_service), 32'(m_phase == M_SVC));
    check("int_vector", 32'(o_int_vector), 32'(m_vec));
    check("int_src",    32'(o_int_src),    32'(m_src));
    check("pending",    32'(o_pending),    32'({m_ps, m_pb, m_pa}));
    check("cfg",        32'(o_cfg),        32'({m_pr, m_eb, m_ea}));
  endtask

  // One clock: inputs already applied at the falling edge; check at the next falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
    i_soft_req = 0; i_cfg_we = 0; i_ack = 0; i_iret = 0;
  endtask

  task automatic run_until_req(input int limit);
    for (int i = 0; i < limit && !o_int_req; i++) cycle();
    check("req_wait", 32'(o_int_req), 32'd1);
  endtask

  task automatic ack_then_iret();
    i_ack = 1; cycle();
    i_iret = 1; cycle();
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [15:0] data);
    i_cfg_we = 1; i_cfg_sel = sel; i_cfg_data = data; cycle();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        inta, ack, iret;
    logic        exp_req, exp_svc;
    logic [15:0] exp_vec;
    logic [1:0]  exp_src;
    logic [2:0]  exp_pend;
  } row_t;

  row_t tbl[7];

  initial begin
    tbl[0] = '{1, 0, 0, 0, 0, 16'h0000, 2'b00, 3'b000};
    tbl[1] = '{1, 0, 0, 0, 0, 16'h0000, 2'b00, 3'b000};
    tbl[2] = '{1, 0, 0, 0, 0, 16'h0000, 2'b00, 3'b001};
    tbl[3] = '{0, 0, 0, 1, 0, 16'hFDA9, 2'b01, 3'b001};
    tbl[4] = '{0, 0, 0, 1, 0, 16'hFDA9, 2'b01, 3'b001};
    tbl[5] = '{0, 1, 0, 0, 1, 16'hFDA9, 2'b01, 3'b000};
    tbl[6] = '{0, 0, 1, 0, 0, 16'h0000, 2'b00, 3'b000};

    i_inta = 0; i_intb = 0; i_soft_req = 0; i_soft_num = 0; i_cfg_we = 0;
    i_cfg_sel = 0; i_cfg_data = 0; i_ack = 0; i_iret = 0;
    n_rst = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_req", 32'(o_int_req), 0);
    check("rst_vec", 32'(o_int_vector), 0);
    check("rst_src", 32'(o_int_src), 0);
    check("rst_svc", 32'(o_in_service), 0);
    check("rst_pend", 32'(o_pending), 0);
    check("rst_cfg", 32'(o_cfg), 32'd3);
    n_rst = 1;

    // Single INTA through the full handshake.
    for (int r = 0; r < 7; r++) begin
      i_inta = tbl[r].inta; i_ack = tbl[r].ack; i_iret = tbl[r].iret;
      cycle();
      check($sformatf("tbl%0d_req", r),  32'(o_int_req),    32'(tbl[r].exp_req));
      check($sformatf("tbl%0d_svc", r),  32'(o_in_service), 32'(tbl[r].exp_svc));
      check($sformatf("tbl%0d_vec", r),  32'(o_int_vector), 32'(tbl[r].exp_vec));
      check($sformatf("tbl%0d_src", r),  32'(o_int_src),    32'(tbl[r].exp_src));
      check($sformatf("tbl%0d_pend", r), 32'(o_pending),    32'(tbl[r].exp_pend));
    end

    // Simultaneous A and B, priority 0 then priority 1.
    for (int p = 0; p < 2; p++) begin
      cfg_write(2'b00, {13'd0, 1'(p), 2'b11});
      i_inta = 1; i_intb = 1;
      run_until_req(10);
      check("dual_first_src", 32'(o_int_src), p ? 32'd2 : 32'd1);
      check("dual_first_vec", 32'(o_int_vector), p ? 32'hFB53 : 32'hFDA9);
      i_inta = 0; i_intb = 0;
      ack_then_iret();
      run_until_req(10);
      check("dual_second_src", 32'(o_int_src), p ? 32'd1 : 32'd2);
      check("dual_second_vec", 32'(o_int_vector), p ? 32'hFDA9 : 32'hFB53);
      ack_then_iret();
    end
    cfg_write(2'b00, 16'h0003);

    // Software interrupt alone, then together with INTB.
    i_soft_req = 1; i_soft_num = 5; cycle();
    run_until_req(5);
    check("soft5_vec", 32'(o_int_vector), 32'h0150);
    check("soft5_src", 32'(o_int_src), 32'd3);
    ack_then_iret();
    i_intb = 1; cycle(); cycle();
    i_soft_req = 1; i_soft_num = 3; cycle();
    check("both_pend", 32'(o_pending), 32'b110);
    run_until_req(5);
    check("soft_vs_b_src", 32'(o_int_src), 32'd2);
    i_intb = 0;
    ack_then_iret();
    run_until_req(5);
    check("soft3_vec", 32'(o_int_vector), 32'h0130);
    ack_then_iret();

    // INTB arriving during service waits for iret; stray ack in service ignored.
    i_inta = 1;
    run_until_req(10);
    i_inta = 0;
    i_ack = 1; cycle();
    i_intb = 1;
    repeat (5) cycle();
    check("svc_b_pend", 32'(o_pending), 32'b010);
    check("svc_no_req", 32'(o_int_req), 0);
    i_ack = 1; cycle();
    check("svc_extra_ack", 32'(o_in_service), 1);
    i_iret = 1; cycle();
    check("iret_idle_req", 32'(o_int_req), 0);
    cycle();
    check("rereq_1cyc", 32'(o_int_req), 1);
    check("rereq_src", 32'(o_int_src), 32'd2);
    i_intb = 0;
    ack_then_iret();

    // Vector write during REQ does not disturb the latched vector.
    i_inta = 1;
    run_until_req(10);
    i_inta = 0;
    cfg_write(2'b01, 16'h1234);
    check("vecwr_hold", 32'(o_int_vector), 32'hFDA9);
    ack_then_iret();
    i_inta = 1;
    run_until_req(10);
    check("vecwr_new", 32'(o_int_vector), 32'h1234);
    i_inta = 0;
    ack_then_iret();
    cfg_write(2'b11, 16'h0000);
    i_inta = 1;
    run_until_req(10);
    check("restore_vec", 32'(o_int_vector), 32'hFDA9);
    i_inta = 0;
    ack_then_iret();

    // Disabling INTA while it is pending in IDLE drops it.
    i_inta = 1; cycle(); cycle(); cycle();
    check("dis_pend_set", 32'(o_pending), 32'b001);
    cfg_write(2'b00, 16'h0002);
    check("dis_pend_clr", 32'(o_pending), 0);
    repeat (4) cycle();
    check("dis_no_req", 32'(o_int_req), 0);
    i_inta = 0;
    cfg_write(2'b00, 16'h0003);

    // Asynchronous reset in the middle of a request.
    i_inta = 1;
    run_until_req(10);
    i_inta = 0;
    cfg_write(2'b01, 16'hABCD);
    #1 n_rst = 0;
    #1;
    check("arst_req", 32'(o_int_req), 0);
    check("arst_vec", 32'(o_int_vector), 0);
    check("arst_src", 32'(o_int_src), 0);
    check("arst_pend", 32'(o_pending), 0);
    check("arst_cfg", 32'(o_cfg), 32'd3);
    model_reset();
    @(negedge clk); @(negedge clk);
    n_rst = 1;
    repeat (5) cycle();

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) i_inta = ~i_inta;
      if ($urandom_range(0, 7) == 0) i_intb = ~i_intb;
      i_soft_req = ($urandom_range(0, 9) == 0);
      i_soft_num = 5'($urandom);
      i_ack      = ($urandom_range(0, 2) == 0);
      i_iret     = ($urandom_range(0, 3) == 0);
      i_cfg_we   = ($urandom_range(0, 29) == 0);
      i_cfg_sel  = 2'($urandom_range(0, 3));
      i_cfg_data = 16'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
